// File: rtl/lb_byte_master.sv
// Byte-stream local-bus initiator: decodes write (A5) and read (5A) command frames,
// issues single-cycle bus strobes and returns ACK/NAK or read data on the response stream.
module lb_byte_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              lb_clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              lb_we,
  output logic              lb_re,
  input  logic [DATA_W-1:0] lb_rdata,
  output logic              busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RESP
  } state_t;

  state_t              state, state_d;
  logic                is_wr, is_wr_d;
  logic                resp_rd, resp_rd_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [DATA_W-1:0]   wdata, wdata_d;
  logic [DATA_W-1:0]   rdata, rdata_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [TMO_W-1:0]    tmo, tmo_d;

  logic                rx_ready_d, tx_valid_d, lb_we_d, lb_re_d, busy_d;
  logic [7:0]          tx_data_d;
  logic [ADDR_W-1:0]   lb_addr_d;
  logic [DATA_W-1:0]   lb_wdata_d;

  logic                rx_acc;
  logic                tx_hs;
  logic                resp_last;

  assign rx_acc    = rx_valid & rx_ready;
  assign tx_hs     = tx_valid & tx_ready;
  assign resp_last = !resp_rd || (cnt == CNT_W'(NB - 1));

  // Next-state, datapath and output decode; outputs are registered from the next state.
  always_comb begin
    state_d   = state;
    is_wr_d   = is_wr;
    resp_rd_d = resp_rd;
    addr_d    = addr;
    wdata_d   = wdata;
    rdata_d   = rdata;
    cnt_d     = cnt;
    tmo_d     = tmo;

    unique case (state)
      ST_IDLE: begin
        if (rx_acc) begin
          tmo_d = '0;
          if (rx_data == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else if (rx_data == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = ST_ADDR;
          end else begin
            resp_rd_d = 1'b0;
            rdata_d   = DATA_W'(NAK);
            state_d   = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (rx_acc) begin
          tmo_d   = '0;
          addr_d  = ADDR_W'(rx_data);
          wdata_d = '0;
          cnt_d   = '0;
          state_d = is_wr ? ST_WDATA : ST_BUS_RD;
        end else begin
          tmo_d = tmo + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT)) state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (rx_acc) begin
          tmo_d   = '0;
          wdata_d = wdata | (DATA_W'(rx_data) << {cnt, 3'b000});
          cnt_d   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(NB - 1)) state_d = ST_BUS_WR;
        end else begin
          tmo_d = tmo + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT)) state_d = ST_IDLE;
        end
      end
      ST_BUS_WR: begin
        resp_rd_d = 1'b0;
        rdata_d   = DATA_W'(ACK);
        state_d   = ST_RESP;
      end
      ST_BUS_RD: begin
        resp_rd_d = 1'b1;
        rdata_d   = lb_rdata;
        cnt_d     = '0;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (tx_hs) begin
          if (resp_last) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d = rdata >> 8;
            cnt_d   = cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
    busy_d     = (state_d != ST_IDLE);
    lb_we_d    = (state_d == ST_BUS_WR);
    lb_re_d    = (state_d == ST_BUS_RD);
    lb_addr_d  = (lb_we_d || lb_re_d) ? addr_d : '0;
    lb_wdata_d = lb_we_d ? wdata_d : '0;
    tx_valid_d = (state_d == ST_RESP);
    tx_data_d  = tx_valid_d ? rdata_d[7:0] : 8'h00;
  end

  always_ff @(posedge lb_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      is_wr    <= 1'b0;
      resp_rd  <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      cnt      <= '0;
      tmo      <= '0;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      lb_we    <= 1'b0;
      lb_re    <= 1'b0;
      lb_addr  <= '0;
      lb_wdata <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      is_wr    <= is_wr_d;
      resp_rd  <= resp_rd_d;
      addr     <= addr_d;
      wdata    <= wdata_d;
      rdata    <= rdata_d;
      cnt      <= cnt_d;
      tmo      <= tmo_d;
      rx_ready <= rx_ready_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      lb_we    <= lb_we_d;
      lb_re    <= lb_re_d;
      lb_addr  <= lb_addr_d;
      lb_wdata <= lb_wdata_d;
      busy     <= busy_d;
    end
  end

endmodule
